// File: rtl/rom_blitter.sv
// rom_blitter: streams an IMG_W x IMG_H image from a synchronous ROM to a
// pixel write port at an arbitrary (x, y) origin, one pixel per clock.
// Optional feature macro: BLIT_TRANSPARENT_EN (pixels equal to KEY_COLOUR
// are not plotted).
module rom_blitter #(
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned X_W        = 9,
    parameter int unsigned Y_W        = 8,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned COLOUR_W   = 6,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned KEY_COLOUR = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x_origin,
    input  logic [Y_W-1:0]      y_origin,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [X_W-1:0]     x_org;
    logic [Y_W-1:0]     y_org;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

    logic [COL_W-1:0]   tag_col [ROM_LAT];
    logic [ROW_W-1:0]   tag_row [ROM_LAT];
    logic [ROM_LAT-1:0] tag_vld;

    logic col_last_c;
    logic last_c;
    logic pipe_empty_c;
    logic accept_c;
    logic issue_c;
    logic busy_c;
    logic done_c;
    logic key_hit_c;

    assign col_last_c   = (col == COL_W'(IMG_W - 1));
    assign last_c       = col_last_c && (row == ROW_W'(IMG_H - 1));
    assign pipe_empty_c = (tag_vld == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: drain waits for the final tag to leave the pipeline
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last_c) next_state = S_DRAIN;
            S_DRAIN: if (pipe_empty_c) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode; busy/done are decoded from next_state so their registers track the state
    always_comb begin
        accept_c = 1'b0;
        issue_c  = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        accept_c = (state == S_IDLE) && start;
        issue_c  = (state == S_RUN);
        busy_c   = (next_state == S_RUN) || (next_state == S_DRAIN);
        done_c   = (next_state == S_DONE);
    end

`ifdef BLIT_TRANSPARENT_EN
    assign key_hit_c = (rom_q == COLOUR_W'(KEY_COLOUR));
`else
    assign key_hit_c = 1'b0;
`endif

    // Address counters, tag pipeline and registered pixel outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            rom_addr <= '0;
            x_org    <= '0;
            y_org    <= '0;
            col      <= '0;
            row      <= '0;
            tag_vld  <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                tag_col[i] <= '0;
                tag_row[i] <= '0;
            end
        end else begin
            busy <= busy_c;
            done <= done_c;

            if (accept_c) begin
                x_org    <= x_origin;
                y_org    <= y_origin;
                col      <= '0;
                row      <= '0;
                rom_addr <= '0;
            end else if (issue_c) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                if (col_last_c) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            tag_vld[0] <= issue_c;
            tag_col[0] <= col;
            tag_row[0] <= row;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_col[i] <= tag_col[i-1];
                tag_row[i] <= tag_row[i-1];
            end

            plot <= tag_vld[ROM_LAT-1] && !key_hit_c;
            if (tag_vld[ROM_LAT-1]) begin
                x      <= x_org + X_W'(tag_col[ROM_LAT-1]);
                y      <= y_org + Y_W'(tag_row[ROM_LAT-1]);
                colour <= rom_q;
            end
        end
    end

endmodule
